// File: rtl/hazard_forward_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_forward_ctrl
//
// Purpose:
//   Decode-side hazard unit. It keeps a three-deep shadow copy of the
//   destinations of the older in-flight instructions (S0 = now in EX, S1 and S2
//   older). From that copy it works out the forwarding selects that the execute
//   forwarding muxes will need, and registers them into EX together with the
//   instruction. It raises a combinational load-use stall, which inserts a
//   bubble. A flush kills the decode instruction.
//
// Select encoding (matches the execute muxes):
//   2'b00 register file / immediate, 2'b01 producer three ahead (mem_haz),
//   2'b10 producer two ahead (ex_haz), 2'b11 producer one ahead (id_haz).
//
// Parameters:
//   REG_ADDR_W  register index width (index 0 is hardwired zero)
//   LOAD_LAT    stall cycles for a consumer directly behind a load (1 or 2)
//
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   id_valid             decode holds a real instruction
//   id_rs1, id_rs2       source indices
//   id_use_rs1           rs1 is read (ALU operand A / jr target)
//   id_use_rs2_alu       rs2 is ALU operand B (0 selects the immediate)
//   id_is_store          rs2 is store data
//   id_rd, id_reg_write  destination index and write enable
//   id_is_load           instruction is a load
//   flush                kill the decode instruction (taken branch / jr)
//   stall                hold PC and IF/ID (combinational)
//   alu_selA, alu_selB   registered operand selects for EX
//   store_rs2_forward    registered store-data select for EX
//
// Optional feature (macro HAZARD_PERF_CNT_EN):
//   stall_cnt  counts cycles with stall=1
//   fwd_cnt    counts issued instructions that register a nonzero select
//   Both counters wrap at 2^32.
// -----------------------------------------------------------------------------
module hazard_forward_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned LOAD_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2_alu,
  input  logic                  id_is_store,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic                  stall,
  output logic [1:0]            alu_selA,
  output logic [1:0]            alu_selB,
  output logic [1:0]            store_rs2_forward
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           fwd_cnt
`endif
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } shadow_t;

  localparam shadow_t SHADOW_EMPTY = '{valid: 1'b0, rd: {REG_ADDR_W{1'b0}},
                                       reg_write: 1'b0, is_load: 1'b0};

  // An entry produces register r; writes to x0 are discarded so never match.
  function automatic logic entry_hit(input shadow_t e, input logic [REG_ADDR_W-1:0] r);
    return e.valid && e.reg_write && (e.rd == r) && (r != {REG_ADDR_W{1'b0}});
  endfunction

  // Same as entry_hit but only for loads, whose data is not ready in time.
  function automatic logic entry_load_hit(input shadow_t e, input logic [REG_ADDR_W-1:0] r);
    return entry_hit(e, r) && e.is_load;
  endfunction

  // Youngest producer wins so the most recent value of r is forwarded.
  function automatic logic [1:0] fwd_sel(input shadow_t e0, input shadow_t e1,
                                         input shadow_t e2,
                                         input logic [REG_ADDR_W-1:0] r);
    logic [1:0] sel;
    if (entry_hit(e0, r)) begin
      sel = 2'b11;
    end else if (entry_hit(e1, r)) begin
      sel = 2'b10;
    end else if (entry_hit(e2, r)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  shadow_t    s0_q, s1_q, s2_q;
  shadow_t    s0_d;
  logic [1:0] sel_a_q, sel_b_q, sel_st_q;
  logic [1:0] sel_a_d, sel_b_d, sel_st_d;
  logic [1:0] rs1_sel_s, rs2_sel_s;
  logic       use_rs2_s;
  logic       load_hit_rs1_s, load_hit_rs2_s;
  logic       stall_s;
  logic       issue_s;

  // Hazard detection: forwarding selects, load-use stall and next shadow entry.
  always_comb begin
    rs1_sel_s = fwd_sel(s0_q, s1_q, s2_q, id_rs1);
    rs2_sel_s = fwd_sel(s0_q, s1_q, s2_q, id_rs2);
    use_rs2_s = id_use_rs2_alu || id_is_store;

    load_hit_rs1_s = entry_load_hit(s0_q, id_rs1);
    load_hit_rs2_s = entry_load_hit(s0_q, id_rs2);
    // With a two-cycle load the consumer must also wait while the load is in S1.
    if (LOAD_LAT == 32'd2) begin
      load_hit_rs1_s = load_hit_rs1_s || entry_load_hit(s1_q, id_rs1);
      load_hit_rs2_s = load_hit_rs2_s || entry_load_hit(s1_q, id_rs2);
    end else begin
      load_hit_rs1_s = load_hit_rs1_s;
      load_hit_rs2_s = load_hit_rs2_s;
    end

    // A flush kills the decode instruction, so it can never also stall.
    stall_s = id_valid && !flush &&
              ((id_use_rs1 && load_hit_rs1_s) || (use_rs2_s && load_hit_rs2_s));
    issue_s = id_valid && !stall_s && !flush;

    s0_d     = SHADOW_EMPTY;
    sel_a_d  = 2'b00;
    sel_b_d  = 2'b00;
    sel_st_d = 2'b00;
    if (issue_s) begin
      s0_d.valid     = 1'b1;
      s0_d.rd        = id_rd;
      s0_d.reg_write = id_reg_write;
      s0_d.is_load   = id_is_load;
      sel_a_d        = id_use_rs1     ? rs1_sel_s : 2'b00;
      sel_b_d        = id_use_rs2_alu ? rs2_sel_s : 2'b00;
      sel_st_d       = id_is_store    ? rs2_sel_s : 2'b00;
    end else begin
      s0_d     = SHADOW_EMPTY;
      sel_a_d  = 2'b00;
      sel_b_d  = 2'b00;
      sel_st_d = 2'b00;
    end
  end

  // Shadow pipeline and EX select registers; older entries always advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q     <= SHADOW_EMPTY;
      s1_q     <= SHADOW_EMPTY;
      s2_q     <= SHADOW_EMPTY;
      sel_a_q  <= 2'b00;
      sel_b_q  <= 2'b00;
      sel_st_q <= 2'b00;
    end else begin
      s0_q     <= s0_d;
      s1_q     <= s0_q;
      s2_q     <= s1_q;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
      sel_st_q <= sel_st_d;
    end
  end

  // Stall is combinational, but rst forces it low even while a load is in S0.
  assign stall             = stall_s && !rst;
  assign alu_selA          = sel_a_q;
  assign alu_selB          = sel_b_q;
  assign store_rs2_forward = sel_st_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, fwd_cnt_q;
  logic        fwd_evt_s;

  assign fwd_evt_s = issue_s && ((sel_a_d != 2'b00) || (sel_b_d != 2'b00) ||
                                 (sel_st_d != 2'b00));

  // Performance counters; free-running, wrap naturally at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      fwd_cnt_q   <= 32'd0;
    end else begin
      stall_cnt_q <= stall_s   ? stall_cnt_q + 32'd1 : stall_cnt_q;
      fwd_cnt_q   <= fwd_evt_s ? fwd_cnt_q + 32'd1   : fwd_cnt_q;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_ctrl
//
// Directed bench for hazard_forward_ctrl. Two instances share one stimulus
// stream: dut1 with LOAD_LAT=1 and dut2 with LOAD_LAT=2. They behave the same
// except around load-use stalls, where each is checked against its own
// hand-computed expectation.
// -----------------------------------------------------------------------------
module tb_hazard_forward_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2_alu, id_is_store;
  logic       id_reg_write, id_is_load;
  logic       flush;

  logic       stall1, stall2;
  logic [1:0] sela1, selb1, selst1;
  logic [1:0] sela2, selb2, selst2;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] scnt1, fcnt1, scnt2, fcnt2;
`endif

  int tests_run;
  int tests_failed;

  hazard_forward_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2_alu(id_use_rs2_alu),
    .id_is_store(id_is_store), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .flush(flush), .stall(stall1),
    .alu_selA(sela1), .alu_selB(selb1), .store_rs2_forward(selst1)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(scnt1), .fwd_cnt(fcnt1)
`endif
  );

  hazard_forward_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2_alu(id_use_rs2_alu),
    .id_is_store(id_is_store), .id_rd(id_rd), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .flush(flush), .stall(stall2),
    .alu_selA(sela2), .alu_selB(selb2), .store_rs2_forward(selst2)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(scnt2), .fwd_cnt(fcnt2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; id_rd = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2_alu = 1'b0; id_is_store = 1'b0;
    id_reg_write = 1'b0; id_is_load = 1'b0; flush = 1'b0;
  endtask

  // Present an ALU op rd = rs1 op rs2 (both sources read).
  task automatic alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    idle();
    id_valid = 1'b1; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = 1'b1; id_use_rs2_alu = 1'b1; id_reg_write = 1'b1;
  endtask

  // Present a load rd = mem[rs1].
  task automatic load(input logic [4:0] rd, input logic [4:0] rs1);
    idle();
    id_valid = 1'b1; id_rd = rd; id_rs1 = rs1;
    id_use_rs1 = 1'b1; id_reg_write = 1'b1; id_is_load = 1'b1;
  endtask

  // Present a store mem[rs1] = rs2.
  task automatic store(input logic [4:0] rs1, input logic [4:0] rs2);
    idle();
    id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = 1'b1; id_is_store = 1'b1;
  endtask

  task automatic drain();
    idle();
    repeat (3) step();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_stall",  {31'd0, stall1}, 32'd0);
    check_eq("rst_selA",   {30'd0, sela1},  32'd0);
    check_eq("rst_selB",   {30'd0, selb1},  32'd0);
    check_eq("rst_selSt",  {30'd0, selst1}, 32'd0);
    rst = 1'b0;

    // add x5,x1,x2 ; add x6,x5,x7 back to back
    alu(5'd5, 5'd1, 5'd2);
    check_eq("raw_first_stall", {31'd0, stall1}, 32'd0);
    step();
    alu(5'd6, 5'd5, 5'd7);
    id_use_rs2_alu = 1'b1;
    #1;
    check_eq("raw_stall", {31'd0, stall1}, 32'd0);
    step();
    check_eq("raw_selA", {30'd0, sela1}, 32'd3);
    check_eq("raw_selB", {30'd0, selb1}, 32'd0);
    check_eq("raw_selA_l2", {30'd0, sela2}, 32'd3);

    // add x5 ; nop ; nop ; sw x5 -> mem_haz
    alu(5'd5, 5'd1, 5'd2);
    step();
    idle(); step();
    idle(); step();
    store(5'd1, 5'd5);
    #1;
    check_eq("st3_stall", {31'd0, stall1}, 32'd0);
    step();
    check_eq("st3_fwd",  {30'd0, selst1}, 32'd1);
    check_eq("st3_selA", {30'd0, sela1},  32'd0);
    check_eq("st3_selB", {30'd0, selb1},  32'd0);

    // add x5 ; nop ; sw x5 -> ex_haz
    alu(5'd5, 5'd1, 5'd2);
    step();
    idle(); step();
    store(5'd1, 5'd5);
    step();
    check_eq("st2_fwd", {30'd0, selst1}, 32'd2);

    // add x5 ; add x9 ; add x5 ; use x5 -> youngest (S0) wins
    alu(5'd5, 5'd1, 5'd2); step();
    alu(5'd9, 5'd1, 5'd2); step();
    alu(5'd5, 5'd1, 5'd2); step();
    alu(5'd10, 5'd5, 5'd5); step();
    check_eq("young_selA", {30'd0, sela1}, 32'd3);
    check_eq("young_selB", {30'd0, selb1}, 32'd3);

    // add x0,x1,x2 ; add x3,x0,x0 -> no forwarding
    alu(5'd0, 5'd1, 5'd2); step();
    alu(5'd3, 5'd0, 5'd0);
    #1;
    check_eq("x0_stall", {31'd0, stall1}, 32'd0);
    step();
    check_eq("x0_selA", {30'd0, sela1}, 32'd0);
    check_eq("x0_selB", {30'd0, selb1}, 32'd0);
    // lw x0 ; use x0 -> no stall
    load(5'd0, 5'd1); step();
    alu(5'd3, 5'd0, 5'd0);
    #1;
    check_eq("lwx0_stall",    {31'd0, stall1}, 32'd0);
    check_eq("lwx0_stall_l2", {31'd0, stall2}, 32'd0);
    step();
    check_eq("lwx0_selA", {30'd0, sela1}, 32'd0);

    // lw x8 ; add x9,x8,x8 -> load-use stall
    drain();
    load(5'd8, 5'd1); step();
    alu(5'd9, 5'd8, 5'd8);
    #1;
    check_eq("lu_stall_c0",    {31'd0, stall1}, 32'd1);
    check_eq("lu_stall_c0_l2", {31'd0, stall2}, 32'd1);
    step();
    check_eq("lu_bubble_selA", {30'd0, sela1},  32'd0);
    check_eq("lu_bubble_selB", {30'd0, selb1},  32'd0);
    check_eq("lu_stall_c1",    {31'd0, stall1}, 32'd0);
    check_eq("lu_stall_c1_l2", {31'd0, stall2}, 32'd1);
    step();
    check_eq("lu_selA",         {30'd0, sela1},  32'd2);
    check_eq("lu_selB",         {30'd0, selb1},  32'd2);
    check_eq("lu_bubble_l2",    {30'd0, sela2},  32'd0);
    check_eq("lu_stall_c2_l2",  {31'd0, stall2}, 32'd0);
    step();
    check_eq("lu_selA_l2", {30'd0, sela2}, 32'd1);
    check_eq("lu_selB_l2", {30'd0, selb2}, 32'd1);

    // lw x4 ; add x5,x4,x1 with flush during the stall cycle
    drain();
    load(5'd4, 5'd2); step();
    alu(5'd5, 5'd4, 5'd1);
    #1;
    check_eq("fl_pre_stall", {31'd0, stall1}, 32'd1);
    flush = 1'b1;
    #1;
    check_eq("fl_stall",    {31'd0, stall1}, 32'd0);
    check_eq("fl_stall_l2", {31'd0, stall2}, 32'd0);
    step();
    check_eq("fl_selA", {30'd0, sela1}, 32'd0);
    check_eq("fl_selB", {30'd0, selb1}, 32'd0);
    flush = 1'b0;
    #1;
    // The load survived the flush and is now in S1.
    check_eq("fl_s1_stall",    {31'd0, stall1}, 32'd0);
    check_eq("fl_s1_stall_l2", {31'd0, stall2}, 32'd1);
    step();
    check_eq("fl_s1_selA", {30'd0, sela1}, 32'd2);
    check_eq("fl_s1_selB", {30'd0, selb1}, 32'd0);

    // Reset asserted mid-stall
    drain();
    alu(5'd1, 5'd2, 5'd3); step();
    load(5'd4, 5'd1); step();
    alu(5'd5, 5'd4, 5'd6);
    #1;
    check_eq("mr_pre_selA",  {30'd0, sela1},  32'd3);
    check_eq("mr_pre_stall", {31'd0, stall1}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("mr_stall",    {31'd0, stall1}, 32'd0);
    check_eq("mr_stall_l2", {31'd0, stall2}, 32'd0);
    check_eq("mr_selA",     {30'd0, sela1},  32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check_eq("mr_scnt", scnt1, 32'd0);
    check_eq("mr_fcnt", fcnt1, 32'd0);
`endif
    #1;
    rst = 1'b0;
    #1;
    check_eq("mr_post_stall", {31'd0, stall1}, 32'd0);
    step();
    check_eq("mr_post_selA", {30'd0, sela1}, 32'd0);
    check_eq("mr_post_selB", {30'd0, selb1}, 32'd0);
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
